rate_tick_sel: RTL and testbench
================================

# rate_tick_sel

Parametrised rate generator and glitch-free rate selector for the clock/stopwatch datapath. Runs entirely on the system clock. Produces one-cycle tick enables at NUM_RATES power-of-two-related rates, instead of muxing divided clocks. Selects one of them under control of `sel` (normal vs. adjust speed and beyond). The rate change is deferred to a common tick boundary, so the downstream counter never sees a short or doubled tick interval.

## Interface
- BASE_DIV, 50_000_000: system-clock cycles per fastest tick (rate 0); minimum 2
- NUM_RATES, 2: number of rates; rate k period = BASE_DIV << k cycles; range 2..8
- SEL_W, derived: clog2(NUM_RATES), minimum 1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- sel  in  SEL_W  requested rate index (from adjust switch/button logic)
- pause  in  1  freezes all counters while high
- tick  out  1  one-cycle pulse at currently applied rate
- tick_all  out  NUM_RATES  one-cycle pulses of every rate, independent of selection
- cur_sel  out  SEL_W  rate index currently applied to `tick`
- switching  out  1  high while a requested change is pending
- phase  out  1  toggles on every `tick` (blink/LED square wave)

## Operation
- Base counter: 0..BASE_DIV-1, increments each non-paused edge, wraps to 0; wrap edge = base boundary.
- Octave counter: NUM_RATES-1 bits, increments on each base boundary, wraps naturally.
- Rate k boundary = base boundary where the low k octave bits are all ones before the increment. Boundaries nest: every rate-k boundary is also a boundary of every rate j<k.
- tick_all[k] is registered high for exactly one cycle after each rate-k boundary edge.
- Sampled select `sel_s` is `sel` registered once (see Configuration). Values >= NUM_RATES are ignored: the target stays unchanged.
- Two-state FSM:
  - IDLE: if sel_s != cur_sel, go to PEND with target = sel_s.
  - PEND: target tracks sel_s every cycle.
  - PEND, target == cur_sel: return to IDLE (cancel); no rate change.
  - PEND, boundary of rate max(cur_sel, target) on this edge: cur_sel <= target, go to IDLE.
- tick = tick_all[cur_sel]. On the switching edge, tick is generated from the new rate, which coincides with the old rate's boundary. No interval is ever shorter than min(old, new) period or longer than max(old, new) period.
- switching = (state == PEND), registered.
- phase toggles on each cycle in which tick is high.
- pause: counters, FSM boundary detection and phase hold. tick/tick_all stay 0. FSM may still cancel in PEND. Release resumes from held counts.

## Timing
- Reset values: tick=0, tick_all=0, cur_sel=0, switching=0, phase=0, all counters 0, FSM=IDLE, sel synchroniser flops 0.
- Reset takes effect immediately (asynchronous); deassertion must be synchronous to clk externally.
- Edge n = nth rising edge after reset release, with pause low.
- tick_all[k] is high in the cycle following edge m·(BASE_DIV << k), m>=1.
- sel to sel_s latency: 1 cycle; 2 cycles with RATE_TICK_SEL_SYNC_EN.
- switching rises 1 cycle after sel_s changes.
- cur_sel updates on the switching edge.
- tick is high on the switching edge at the new rate; switching falls in the same cycle.
- Simultaneous PEND entry and boundary: a boundary on the same edge that sel_s first differs is not used. The switch waits for the next qualifying boundary.

## Configuration
- RATE_TICK_SEL_SYNC_EN defined: `sel` passes through a two-flop synchroniser before sel_s (for raw switch inputs); select latency 2 cycles.
- Not defined: single sampling register; latency 1 cycle. Counter and tick behaviour is identical in both builds.

## Test plan
Bench parameters: BASE_DIV=4, NUM_RATES=3, macro undefined unless stated.
1. Free run, sel=0: tick_all[0] after edges 4,8,12…; [1] after 8,16…; [2] after 16,32…; tick follows [0]; phase toggles at 4,8.
2. sel 0→2 before edge 5: switching high from edge 6; ticks at 8,12 still rate 0; switch at 16 (cur_sel=2, tick high); next tick 32.
3. sel 2→0 before edge 20: switch deferred to edge 32, the rate-2 boundary; subsequent ticks at 36,40.
4. pause high edges 6–9: no ticks; next rate-0 tick after edge 12 instead of 8.
5. sel 0→1 then back to 0 before edge 8: switching rises then falls; cur_sel stays 0; no missed tick.
6. rst asserted mid-PEND at edge 10: all outputs 0 asynchronously; after release, first tick after edge 4. With RATE_TICK_SEL_SYNC_EN defined, scenario 2 switching rises one cycle later; switch still at edge 16.

Source files
------------

// File: rtl/rate_tick_sel_if.sv
// Control/status bundle of the rate generator: select and pause in, tick pulses and status out.
// The design (slave) drives the tick and status signals; the controller (master) drives sel and pause.
interface rate_tick_sel_if #(
  parameter int unsigned NUM_RATES = 2
);
  localparam int unsigned SEL_W = (NUM_RATES > 2) ? $clog2(NUM_RATES) : 1;

  logic [SEL_W-1:0]     sel;
  logic                 pause;
  logic                 tick;
  logic [NUM_RATES-1:0] tick_all;
  logic [SEL_W-1:0]     cur_sel;
  logic                 switching;
  logic                 phase;

  modport master (
    output sel, pause,
    input  tick, tick_all, cur_sel, switching, phase
  );

  modport slave (
    input  sel, pause,
    output tick, tick_all, cur_sel, switching, phase
  );
endinterface

// File: rtl/rate_tick_sel.sv
// Power-of-two tick-enable generator with a rate selector that only switches on a common boundary.
// Optional macro RATE_TICK_SEL_SYNC_EN adds a two-flop synchroniser on the raw select input.
module rate_tick_sel #(
  parameter int unsigned BASE_DIV  = 50_000_000,
  parameter int unsigned NUM_RATES = 2
) (
  input logic           clk,
  input logic           rst,
  rate_tick_sel_if.slave bus
);

  localparam int unsigned    SEL_W       = (NUM_RATES > 2) ? $clog2(NUM_RATES) : 1;
  localparam int unsigned    CNT_W       = $clog2(BASE_DIV);
  localparam int unsigned    OCT_W       = NUM_RATES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BASE_DIV - 1);
  localparam logic [SEL_W:0] NUM_RATES_L = (SEL_W + 1)'(NUM_RATES);

  typedef enum logic {S_IDLE, S_PEND} state_e;

  logic [CNT_W-1:0]     base_cnt_q, base_cnt_d;
  logic [OCT_W-1:0]     oct_q, oct_d;
  logic                 base_wrap;
  logic [NUM_RATES-1:0] bnd;

  logic [SEL_W-1:0]     sel_s_q;
  state_e               state_q;
  logic [SEL_W-1:0]     target_q;
  logic [SEL_W-1:0]     cur_sel_q;
  logic                 switching_q;
  logic                 tick_q;
  logic [NUM_RATES-1:0] tick_all_q;
  logic                 phase_q;

  logic                 sel_ok;
  logic [SEL_W-1:0]     max_sel;
  logic                 cancel;
  logic                 do_switch;
  logic                 tick_d;

  // Base and octave counters; pause freezes both and suppresses every boundary.
  assign base_wrap = !bus.pause && (base_cnt_q == CNT_MAX);

  always_comb begin
    base_cnt_d = base_cnt_q;
    oct_d      = oct_q;
    if (base_wrap) begin
      base_cnt_d = '0;
      oct_d      = oct_q + OCT_W'(1);
    end else if (!bus.pause) begin
      base_cnt_d = base_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_cnt_q <= '0;
      oct_q      <= '0;
    end else begin
      base_cnt_q <= base_cnt_d;
      oct_q      <= oct_d;
    end
  end

  // Rate k boundary: base wrap with the low k octave bits all ones, so boundaries nest.
  assign bnd[0] = base_wrap;
  for (genvar k = 1; k < NUM_RATES; k++) begin : g_bnd
    assign bnd[k] = base_wrap & (&oct_q[k-1:0]);
  end

`ifdef RATE_TICK_SEL_SYNC_EN
  logic [SEL_W-1:0] sel_meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_meta_q <= '0;
      sel_s_q    <= '0;
    end else begin
      sel_meta_q <= bus.sel;
      sel_s_q    <= sel_meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_s_q <= '0;
    else     sel_s_q <= bus.sel;
  end
`endif

  // Out-of-range requests are ignored so the target never points past the last rate.
  assign sel_ok    = {1'b0, sel_s_q} < NUM_RATES_L;
  assign max_sel   = (target_q > cur_sel_q) ? target_q : cur_sel_q;
  assign cancel    = (state_q == S_PEND) && (target_q == cur_sel_q);
  assign do_switch = (state_q == S_PEND) && !cancel && bnd[max_sel];
  assign tick_d    = do_switch ? bnd[target_q] : bnd[cur_sel_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      cur_sel_q   <= '0;
      switching_q <= 1'b0;
      tick_q      <= 1'b0;
      tick_all_q  <= '0;
      phase_q     <= 1'b0;
    end else begin
      tick_all_q <= bnd;
      tick_q     <= tick_d;
      phase_q    <= phase_q ^ tick_d;
      case (state_q)
        S_IDLE: begin
          if (sel_ok && (sel_s_q != cur_sel_q)) begin
            state_q     <= S_PEND;
            target_q    <= sel_s_q;
            switching_q <= 1'b1;
          end
        end
        S_PEND: begin
          if (sel_ok) target_q <= sel_s_q;
          if (cancel || do_switch) begin
            state_q     <= S_IDLE;
            switching_q <= 1'b0;
          end
          if (do_switch) cur_sel_q <= target_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tick      = tick_q;
  assign bus.tick_all  = tick_all_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.switching = switching_q;
  assign bus.phase     = phase_q;

endmodule

// File: tb/tb_rate_tick_sel.sv
// Directed bench for rate_tick_sel with BASE_DIV=4, NUM_RATES=3, default build.
module tb_rate_tick_sel;
  localparam int unsigned BASE_DIV  = 4;
  localparam int unsigned NUM_RATES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   edge_n;

  always #5 clk = ~clk;

  rate_tick_sel_if #(.NUM_RATES(NUM_RATES)) bus ();

  rate_tick_sel #(
    .BASE_DIV (BASE_DIV),
    .NUM_RATES(NUM_RATES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Edge n = nth rising edge after reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic et, input logic [2:0] ea,
                            input logic [1:0] ec, input logic es, input logic ep);
    check({tag, "_tick"}, 32'(bus.tick), 32'(et));
    check({tag, "_all"},  32'(bus.tick_all), 32'(ea));
    check({tag, "_cur"},  32'(bus.cur_sel), 32'(ec));
    check({tag, "_sw"},   32'(bus.switching), 32'(es));
    check({tag, "_ph"},   32'(bus.phase), 32'(ep));
  endtask

  // Advance to 1 time unit after edge n.
  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (edge_n < n && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check($sformatf("edge_sync_%0d", n), 32'(edge_n), 32'(n));
  endtask

  function automatic logic [2:0] free_all(input int e);
    free_all = {(e % 16) == 0, (e % 8) == 0, (e % 4) == 0};
  endfunction

  task automatic do_reset();
    bus.sel   = '0;
    bus.pause = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_outs("rst", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
  endtask

  // Expected outputs after each edge for scenario id, then stimulus for the next edge.
  task automatic run_case(input int id, input int last);
    logic       ph;
    logic       et;
    logic       es;
    logic [1:0] ec;
    logic [2:0] ea;
    ph = 1'b0;
    for (int n = 1; n <= last; n++) begin
      run_to(n);
      ea = free_all(n);
      ec = 2'd0;
      es = 1'b0;
      et = ea[0];
      case (id)
        2: begin
          et = (n < 16 || n >= 32) ? ea[0] : ea[2];
          ec = (n >= 16 && n < 32) ? 2'd2 : 2'd0;
          es = (n >= 6 && n < 16) || (n >= 21 && n < 32);
        end
        4: begin
          ea = (n >= 6 && n <= 9) ? 3'b000 : free_all((n >= 10) ? n - 4 : n);
          et = ea[0];
        end
        5: es = (n == 6) || (n == 7);
        6: es = (n >= 6);
        default: ;
      endcase
      ph = ph ^ et;
      check_outs($sformatf("c%0d_e%0d", id, n), et, ea, ec, es, ph);
      case (id)
        2: if (n == 4) bus.sel = 2'd2; else if (n == 19) bus.sel = 2'd0;
        4: if (n == 5) bus.pause = 1'b1; else if (n == 9) bus.pause = 1'b0;
        5: if (n == 4) bus.sel = 2'd1; else if (n == 5) bus.sel = 2'd0;
        6: if (n == 4) bus.sel = 2'd2;
        default: ;
      endcase
    end
  endtask

  initial begin
    bus.sel   = '0;
    bus.pause = 1'b0;

    do_reset();
    run_case(1, 16);

    do_reset();
    run_case(2, 41);

    do_reset();
    run_case(4, 24);

    do_reset();
    run_case(5, 12);

    // Asynchronous reset while a change is pending.
    do_reset();
    run_case(6, 10);
    #2;
    rst = 1'b1;
    #1;
    check_outs("arst", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0);
    bus.sel = '0;
    @(negedge clk);
    rst = 1'b0;
    run_case(1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
